// File: rtl/dwt_ctrl.sv
// dwt_ctrl: block-mode sequencer for one dwt_core instance.
//
// Purpose
//   Paces the core with iclk_ena / iclk_enax2 strobes derived from a pDIV
//   divider and feeds it one block of ilen samples. Samples arrive from the
//   source through a one-entry skid register. The block is followed by
//   pFLUSH zero samples. H/L coefficient pairs are collected on every
//   core ena strobe that carries core oena. Completion is signalled when
//   enough pairs have arrived, or when the DRAIN watchdog expires.
//
// Handshake (idat/ival/ordy)
//   A sample transfers on a rising clock edge where ival && ordy. ordy does
//   not depend on ival. The source must hold idat stable while ival is high
//   and ordy is low.
//
// Ports
//   iclk, irst          clock, asynchronous active-high reset
//   istart, ilen        start pulse and block length (accepted only in IDLE)
//   idat, ival, ordy    sample input handshake
//   ocore_clk_ena       core iclk_ena strobe (divider count == pDIV-1)
//   ocore_clk_enax2     core iclk_enax2 strobe (count == pDIV/2-1 or pDIV-1)
//   ocore_rst           one-cycle clear to the core, the cycle after a start
//   ocore_dat, ocore_ena  sample slot to the core, updated on enax2 strobes
//   icore_oena, icore_datH, icore_datL   core results
//   oena, odatH, odatL  captured coefficient pair (oena is a one-cycle pulse)
//   obusy, odone, oerr  status: not idle, completion pulse, sticky error
//   ounder_cnt          lost FEED slots, saturating (only with the macro below)
//
// Build option
//   DWT_CTRL_UNDERRUN_CNT_EN: adds ounder_cnt[15:0].

module dwt_ctrl #(
  parameter int pWIDTH   = 16,
  parameter int pDIV     = 16,
  parameter int pFLUSH   = 10,
  parameter int pLEN_W   = 16,
  parameter int pTIMEOUT = 64
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  istart,
  input  logic [pLEN_W-1:0]     ilen,
  input  logic [pWIDTH-1:0]     idat,
  input  logic                  ival,
  output logic                  ordy,
  output logic                  ocore_clk_ena,
  output logic                  ocore_clk_enax2,
  output logic                  ocore_rst,
  output logic [pWIDTH-1:0]     ocore_dat,
  output logic                  ocore_ena,
  input  logic                  icore_oena,
  input  logic [2*pWIDTH-1:0]   icore_datH,
  input  logic [2*pWIDTH-1:0]   icore_datL,
  output logic                  oena,
  output logic [2*pWIDTH-1:0]   odatH,
  output logic [2*pWIDTH-1:0]   odatL,
  output logic                  obusy,
  output logic                  odone,
`ifdef DWT_CTRL_UNDERRUN_CNT_EN
  output logic [15:0]           ounder_cnt,
`endif
  output logic                  oerr
);

  localparam int CW = (pDIV > 1) ? $clog2(pDIV) : 1;
  localparam int FW = $clog2(pFLUSH + 1);
  localparam int TW = $clog2(pTIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(pDIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(pDIV / 2 - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(pFLUSH);
  localparam logic [TW-1:0] TO_LAST  = TW'(pTIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Divider and strobes
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ena_q, ena_d;
  logic          x2_q, x2_d;
  logic          core_rst_q;

  // Block bookkeeping
  logic [pLEN_W-1:0] len_q;
  logic [pLEN_W-1:0] fed_q;
  logic [pLEN_W-1:0] fed_inc;
  logic [pLEN_W-1:0] pairs_q;
  logic [FW-1:0]     fl_q;
  logic [TW-1:0]     to_q;
  logic [pLEN_W:0]   pair_target;
  logic              drain_met;
  logic              timeout_hit;

  // Skid entry and core sample slot
  logic [pWIDTH-1:0] ent_q;
  logic              full_q;
  logic              cap;
  logic [pWIDTH-1:0] cdat_q;
  logic              cena_q;

  // Result capture and status
  logic                oena_q;
  logic [2*pWIDTH-1:0] odat_h_q;
  logic [2*pWIDTH-1:0] odat_l_q;
  logic                err_q;
  logic                start_ok;

`ifdef DWT_CTRL_UNDERRUN_CNT_EN
  logic [15:0] under_q;
`endif

  // Only nonzero even lengths can be split into whole H/L pairs.
  assign start_ok = istart && (ilen != '0) && !ilen[0];

  assign fed_inc = fed_q + pLEN_W'(1);

  // Every two samples into the core yield one pair, flush samples included.
  assign pair_target = ({1'b0, len_q} + (pLEN_W + 1)'(pFLUSH)) >> 1;
  assign drain_met   = ({1'b0, pairs_q} >= pair_target);

  assign ordy = (state_q == S_FEED) && !full_q && (fed_q < len_q);
  assign cap  = ival && ordy;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and divider next value
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    cnt_d       = '0;
    ena_d       = 1'b0;
    x2_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_FEED;
      end
      S_FEED: begin
        // Leave on the strobe that hands the last sample to the core.
        if (x2_q && full_q && (fed_inc == len_q)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (x2_q && (fl_q == FL_LAST)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_met) begin
          state_d = S_DONE;
        end else if (ena_q && (to_q == TO_LAST)) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The divider restarts from 0 on the first busy cycle and parks at 0
    // while idle.
    if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Strobes are decoded from the next count so that the registered
    // strobe is high in exactly the cycle the count shows the decoded value.
    ena_d = (state_d != S_IDLE) && (cnt_d == CNT_LAST);
    x2_d  = (state_d != S_IDLE) && ((cnt_d == CNT_HALF) || (cnt_d == CNT_LAST));
  end

  // ---------------------------------------------------------------------
  // Datapath and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt_q      <= '0;
      ena_q      <= 1'b0;
      x2_q       <= 1'b0;
      core_rst_q <= 1'b0;
      len_q      <= '0;
      fed_q      <= '0;
      pairs_q    <= '0;
      fl_q       <= '0;
      to_q       <= '0;
      ent_q      <= '0;
      full_q     <= 1'b0;
      cdat_q     <= '0;
      cena_q     <= 1'b0;
      oena_q     <= 1'b0;
      odat_h_q   <= '0;
      odat_l_q   <= '0;
      err_q      <= 1'b0;
`ifdef DWT_CTRL_UNDERRUN_CNT_EN
      under_q    <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      ena_q      <= ena_d;
      x2_q       <= x2_d;
      core_rst_q <= 1'b0;
      oena_q     <= 1'b0;

      if (state_q == S_IDLE) begin
        if (start_ok) begin
          len_q      <= ilen;
          fed_q      <= '0;
          pairs_q    <= '0;
          fl_q       <= '0;
          to_q       <= '0;
          full_q     <= 1'b0;
          cdat_q     <= '0;
          cena_q     <= 1'b0;
          err_q      <= 1'b0;
          core_rst_q <= 1'b1;
`ifdef DWT_CTRL_UNDERRUN_CNT_EN
          under_q    <= '0;
`endif
        end else if (istart) begin
          err_q <= 1'b1;
        end
      end

      // FEED slot: hand the skid entry to the core, or lose the slot.
      if ((state_q == S_FEED) && x2_q) begin
        if (full_q) begin
          cdat_q <= ent_q;
          cena_q <= 1'b1;
          full_q <= 1'b0;
          fed_q  <= fed_inc;
        end else begin
          cena_q <= 1'b0;
          err_q  <= 1'b1;
`ifdef DWT_CTRL_UNDERRUN_CNT_EN
          if (under_q != 16'hFFFF) under_q <= under_q + 16'd1;
`endif
        end
      end

      // Placed after the slot update so a same-cycle refill wins.
      if (cap) begin
        ent_q  <= idat;
        full_q <= 1'b1;
      end

      // FLUSH slots carry zeros; the slot after the last one is idle.
      if ((state_q == S_FLUSH) && x2_q) begin
        cdat_q <= '0;
        if (fl_q == FL_LAST) begin
          cena_q <= 1'b0;
        end else begin
          cena_q <= 1'b1;
          fl_q   <= fl_q + FW'(1);
        end
      end

      if ((state_q == S_DRAIN) && ena_q) begin
        to_q <= to_q + TW'(1);
      end

      if (timeout_hit) begin
        err_q <= 1'b1;
      end

      // Results are valid in the cycle the core is enabled.
      if ((state_q != S_IDLE) && ena_q && icore_oena) begin
        odat_h_q <= icore_datH;
        odat_l_q <= icore_datL;
        oena_q   <= 1'b1;
        pairs_q  <= pairs_q + pLEN_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign ocore_clk_ena   = ena_q;
  assign ocore_clk_enax2 = x2_q;
  assign ocore_rst       = core_rst_q;
  assign ocore_dat       = cdat_q;
  assign ocore_ena       = cena_q;
  assign oena            = oena_q;
  assign odatH           = odat_h_q;
  assign odatL           = odat_l_q;
  assign obusy           = (state_q != S_IDLE);
  assign odone           = (state_q == S_DONE);
  assign oerr            = err_q;
`ifdef DWT_CTRL_UNDERRUN_CNT_EN
  assign ounder_cnt      = under_q;
`endif

endmodule

// File: doc/dwt_ctrl.md
Name: dwt_ctrl

Overview:
Block-mode sequencer for dwt_core. It generates the core's iclk_ena and iclk_enax2 strobes from a programmable divider and feeds it one length-ilen block of samples through a valid/ready handshake. After the block it appends pFLUSH zero samples. It then collects the H/L coefficient pairs and signals completion. It sits between the sample source and one dwt_core instance and owns every core control input.

Parameters:
pWIDTH, 16, sample width; the core returns 2*pWIDTH-bit coefficients
pDIV, 16, iclk cycles per core iclk_ena period; even, >=4
pFLUSH, 10, zero samples appended after the block; even
pLEN_W, 16, width of block length
pTIMEOUT, 64, max iclk_ena periods spent in DRAIN

Ports:
iclk  in  1  clock
irst  in  1  asynchronous reset, active-high
istart  in  1  start pulse, accepted only in IDLE
ilen  in  pLEN_W  block length in samples, latched on accepted istart
idat  in  pWIDTH  input sample
ival  in  1  idat valid
ordy  out  1  ready for idat
ocore_clk_ena  out  1  to core iclk_ena
ocore_clk_enax2  out  1  to core iclk_enax2
ocore_rst  out  1  synchronous one-cycle clear to core state
ocore_dat  out  pWIDTH  to core idat
ocore_ena  out  1  to core iena
icore_oena  in  1  core oena
icore_datH  in  2*pWIDTH  core odatH
icore_datL  in  2*pWIDTH  core odatL
oena  out  1  output pair valid, one-cycle pulse
odatH  out  2*pWIDTH  captured high-pass coefficient
odatL  out  2*pWIDTH  captured low-pass coefficient
obusy  out  1  state != IDLE
odone  out  1  one-cycle pulse on block completion
oerr  out  1  sticky error flag; cleared by the next accepted istart

Behaviour:
- Reset: all outputs 0, state IDLE, divider 0, all counters 0.
- FSM states: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - istart with ilen even and nonzero is accepted in cycle T; ilen is latched.
  - T+1: ocore_rst=1 for exactly one cycle, divider cleared to 0, state FEED.
  - istart with ilen==0 or ilen odd: oerr=1, stay IDLE.
- Divider cnt runs 0..pDIV-1 whenever state != IDLE and wraps at pDIV-1.
  - ocore_clk_enax2 is high for one cycle when cnt==pDIV/2-1 or cnt==pDIV-1.
  - ocore_clk_ena is high for one cycle when cnt==pDIV-1.
  - Both strobes are registered and mutually aligned; both are 0 in IDLE.
- Input skid register, one entry:
  - ordy = (state==FEED) and entry empty and fed<ilen.
  - A sample is captured on ival&&ordy.
- At each enax2 strobe in FEED:
  - Entry full: ocore_dat=entry, ocore_ena=1, entry cleared, fed++.
  - Entry empty: ocore_ena=0 for that slot, oerr=1. The slot is lost and fed is unchanged.
  - ocore_dat and ocore_ena hold until the next enax2 strobe.
  - A capture in the same cycle as a strobe that empties the entry is legal; the entry refills next cycle.
- fed==ilen at a strobe boundary: state FLUSH.
  - pFLUSH strobes with ocore_dat=0, ocore_ena=1, then state DRAIN with ocore_ena=0.
- Output capture:
  - In any non-IDLE state, in the cycle ocore_clk_ena==1 and icore_oena==1: register icore_datH/L to odatH/L, pulse oena, pairs++.
  - Captures that occur during FEED/FLUSH also count.
- DRAIN exits to DONE when pairs==(ilen+pFLUSH)/2.
  - Also exits on pTIMEOUT ena strobes spent in DRAIN; this sets oerr=1.
- DONE: odone=1 for one cycle, then IDLE. odatH/odatL hold their last values.
- istart while busy is ignored.
- Asynchronous irst at any time returns to the reset state immediately. In-flight samples and pairs are discarded.
- Counters: fed and pairs are pLEN_W bits. Saturation cannot occur for legal ilen.

Optional Feature:
DWT_CTRL_UNDERRUN_CNT_EN
- Defined: adds output ounder_cnt[15:0].
  - Counts FEED slots lost to an empty entry; saturates at 16'hFFFF.
  - Cleared on accepted istart and on irst.
- Undefined: port and counter absent; underrun is reported only through oerr.

Test Plan:
- Strobes: pDIV=16, istart with ilen=64 -> ocore_clk_ena at cnt 15 only; ocore_clk_enax2 at cnt 7 and 15; exactly 1 ocore_rst pulse one cycle after start.
- Full block: ilen=64, ival held 1, core model asserting oena on every ena strobe -> 64 data slots, then 10 zero slots, then 37 oena pulses, then odone one cycle later, oerr=0.
- Underrun: ilen=8, source withholds ival for slot 3 -> that slot has ocore_ena=0 and oerr=1; with the macro, ounder_cnt=1.
- Bad length: istart with ilen=7, then with ilen=0 -> state stays IDLE, obusy=0, oerr=1; a following valid start clears oerr.
- Timeout: core model never asserts oena, ilen=4 -> DRAIN lasts 64 ena periods, then odone with oerr=1.
- Async reset in FLUSH, plus istart while busy -> all outputs 0 immediately after reset; a restart after reset works normally; istart during FEED has no effect.
